seq_mac2c: RTL

- Parametrised, multi-cycle two's-complement multiply-accumulate unit. Successor to the fixed 8x4 combinational carry-save array multiplier.
- Computes the exact signed product P = X*Y with a shift-add datapath, one Y bit per cycle.
- Optionally accumulates P into a wide running sum. Used for MLP neuron dot products.
- Valid/ready handshakes on both the input and output sides.

---
 rtl/seq_mac2c.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seq_mac2c.sv
`default_nettype none
// seq_mac2c: sequential two's-complement shift-add multiplier (one Y bit per cycle)
// with an optional wide accumulator, sticky signed overflow and valid/ready handshakes.
module seq_mac2c #(
  parameter int XW   = 8,
  parameter int YW   = 4,
  parameter int ACCW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [XW-1:0] x,
  input  logic signed [YW-1:0] y,
  input  logic                 acc_en,
  input  logic                 clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XW+YW-1:0]     p,
  output logic [ACCW-1:0]      acc,
  output logic                 ovf
);

  localparam int PW = XW + YW;
  localparam int CW = (YW > 1) ? $clog2(YW) : 1;

  generate
    if (ACCW < XW + YW || YW < 2) begin : g_param_check
      $error("seq_mac2c: requires YW >= 2 and ACCW >= XW+YW");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                   r_rdy;
  logic [CW-1:0]          r_cnt;
  logic [PW-1:0]          r_mcand;
  logic [PW-1:0]          r_sum;
  logic [YW-1:0]          r_y;
  logic                   r_acc_en;
  logic [PW-1:0]          r_p;
  logic [ACCW-1:0]        r_acc;
  logic                   r_ovf;

  logic                   w_accept;
  logic                   w_last;
  logic                   w_clr;
  logic [PW-1:0]          w_pp;
  logic signed [PW-1:0]   w_step;
  logic signed [ACCW-1:0] w_p_sext;
  logic [ACCW-1:0]        w_acc_sum;
  logic                   w_acc_ovf;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid && r_rdy) begin
          w_accept = 1'b1;
          w_next   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == CW'(YW - 1)) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rdy   <= (w_next == S_IDLE);
    end
  end

  // The last cycle sees the Y sign bit, whose weight is negative: subtract it.
  assign w_clr     = clr && (r_state == S_IDLE);
  assign w_pp      = r_y[0] ? r_mcand : '0;
  assign w_step    = w_last ? (r_sum - w_pp) : (r_sum + w_pp);
  assign w_p_sext  = ACCW'(w_step);
  assign w_acc_sum = r_acc + w_p_sext;
  assign w_acc_ovf = r_acc_en && (r_acc[ACCW-1] == w_p_sext[ACCW-1])
                     && (w_acc_sum[ACCW-1] != r_acc[ACCW-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_sum    <= '0;
      r_y      <= '0;
      r_acc_en <= 1'b0;
      r_p      <= '0;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mcand  <= PW'(x);
        r_y      <= y;
        r_acc_en <= acc_en;
        r_sum    <= '0;
        r_cnt    <= '0;
      end else if (r_state == S_BUSY) begin
        r_sum   <= w_step;
        r_mcand <= r_mcand << 1;
        r_y     <= r_y >> 1;
        r_cnt   <= r_cnt + 1'b1;
      end

      if (w_last) begin
        r_p   <= w_step;
        r_acc <= r_acc_en ? w_acc_sum : w_p_sext;
        r_ovf <= r_ovf | w_acc_ovf;
      end else if (w_clr) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end
    end
  end

  assign in_ready  = r_rdy;
  assign out_valid = (r_state == S_DONE);
  assign p         = r_p;
  assign acc       = r_acc;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire
